// File: rtl/down_counter_timer_if.sv
// rtl/down_counter_timer_if.sv - control/status bundle between a controller and the down-counter timer
interface down_counter_timer_if #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
);
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic                  start;
  logic                  pause;
  logic                  stop;
  logic                  auto_reload;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  tc;

  modport master (
    output load, load_val, start, pause, stop, auto_reload, prescale,
    input  count, busy, tc
  );

  modport slave (
    input  load, load_val, start, pause, stop, auto_reload, prescale,
    output count, busy, tc
  );
endinterface

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable prescaled down-counter with terminal-count pulse and auto-reload
module down_counter_timer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  down_counter_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t                state_q, state_n;
  logic [WIDTH-1:0]      count_q, count_n;
  logic [WIDTH-1:0]      reload_q, reload_n;
  logic [PRESCALE_W-1:0] presc_q, presc_n;
  logic                  tc_q, tc_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
      presc_q  <= presc_n;
      tc_q     <= tc_n;
    end
  end

  // Event priority: load > stop > start > pause > tick.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    reload_n = reload_q;
    presc_n  = presc_q;
    tc_n     = 1'b0;

    if (bus.load) begin
      reload_n = bus.load_val;
      count_n  = bus.load_val;
      presc_n  = '0;
      state_n  = IDLE;
    end else if (bus.stop) begin
      presc_n = '0;
      state_n = IDLE;
    end else if (bus.start && state_q == IDLE) begin
      presc_n = '0;
      if (count_q != '0) begin
        state_n = RUN;
      end
    end else if (bus.pause) begin
      if (state_q == RUN) begin
        state_n = PAUSED;
      end
    end else if (state_q == PAUSED) begin
      // Resume cycle: prescaler stays frozen for this one cycle.
      state_n = RUN;
    end else if (state_q == RUN) begin
      // >= so that lowering prescale mid-run ticks immediately instead of wrapping.
      if (presc_q >= bus.prescale) begin
        presc_n = '0;
        if (count_q > WIDTH'(1)) begin
          count_n = count_q - WIDTH'(1);
        end else begin
          tc_n = (count_q == WIDTH'(1));
          if (count_q == WIDTH'(1) && bus.auto_reload && reload_q != '0) begin
            count_n = reload_q;
          end else begin
            count_n = '0;
            state_n = IDLE;
          end
        end
      end else begin
        presc_n = presc_q + PRESCALE_W'(1);
      end
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - randomized and directed check of down_counter_timer against a behavioural model
module tb_down_counter_timer;

  localparam int WIDTH      = 4;
  localparam int PRESCALE_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  down_counter_timer_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

  down_counter_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts remaining ticks and running cycles since the last tick.
  int m_cnt = 0, m_rld = 0, m_elapsed = 0;
  bit m_active = 0, m_frozen = 0, m_tc = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_rld = 0; m_elapsed = 0;
      m_active = 0; m_frozen = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (bus.load) begin
        m_rld = int'(bus.load_val); m_cnt = m_rld; m_elapsed = 0;
        m_active = 0; m_frozen = 0;
      end else if (bus.stop) begin
        m_active = 0; m_frozen = 0; m_elapsed = 0;
      end else if (bus.start && !m_active && !m_frozen) begin
        m_elapsed = 0;
        m_active = (m_cnt != 0);
      end else if (bus.pause) begin
        if (m_active) begin m_active = 0; m_frozen = 1; end
      end else if (m_frozen) begin
        m_frozen = 0; m_active = 1;
      end else if (m_active) begin
        if (m_elapsed >= int'(bus.prescale)) begin
          m_elapsed = 0;
          if (m_cnt == 1) begin
            m_tc = 1;
            if (bus.auto_reload && m_rld != 0) m_cnt = m_rld;
            else begin m_cnt = 0; m_active = 0; end
          end else begin
            m_cnt = m_cnt - 1;
          end
        end else begin
          m_elapsed = m_elapsed + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_count", int'(bus.count), m_cnt);
    chk("model_busy", int'(bus.busy), int'(m_active | m_frozen));
    chk("model_tc", int'(bus.tc), int'(m_tc));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    bus.load = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
  endtask

  task automatic expect_out(input string name, input int c, input int b, input int t);
    chk({name, "_count"}, int'(bus.count), c);
    chk({name, "_busy"}, int'(bus.busy), b);
    chk({name, "_tc"}, int'(bus.tc), t);
  endtask

  int tc_times[$];
  int guard;

  initial begin
    bus.load = 0; bus.load_val = 0; bus.start = 0; bus.pause = 0;
    bus.stop = 0; bus.auto_reload = 0; bus.prescale = 0;
    #1;
    expect_out("reset", 0, 0, 0);
    @(posedge clk); #2; reset = 1'b0;

    // Basic countdown
    bus.load = 1; bus.load_val = 5; cyc();
    expect_out("t1_load", 5, 0, 0);
    bus.start = 1; cyc();
    expect_out("t1_start", 5, 1, 0);
    for (int k = 4; k >= 0; k--) begin
      cyc();
      expect_out("t1_step", k, (k != 0) ? 1 : 0, (k == 0) ? 1 : 0);
    end
    cyc();
    expect_out("t1_hold", 0, 0, 0);

    // Auto-reload with prescale 2: tc every 9 cycles
    bus.prescale = 2; bus.auto_reload = 1;
    bus.load = 1; bus.load_val = 3; cyc();
    bus.start = 1; cyc();
    for (int i = 1; i <= 30; i++) begin
      cyc();
      chk("t2_busy", int'(bus.busy), 1);
      if (bus.count == 0) chk("t2_nonzero", int'(bus.count), 1);
      if (bus.tc) tc_times.push_back(i);
    end
    chk("t2_pulses", tc_times.size(), 3);
    if (tc_times.size() >= 3) begin
      chk("t2_first", tc_times[0], 9);
      chk("t2_period_a", tc_times[1] - tc_times[0], 9);
      chk("t2_period_b", tc_times[2] - tc_times[1], 9);
    end
    bus.auto_reload = 0; bus.stop = 1; cyc();
    chk("t2_stop_busy", int'(bus.busy), 0);

    // Pause
    bus.prescale = 0; bus.load = 1; bus.load_val = 4; cyc();
    bus.start = 1; cyc();
    cyc(); cyc();
    expect_out("t3_pre", 2, 1, 0);
    bus.pause = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_out("t3_paused", 2, 1, 0);
    end
    bus.pause = 0; cyc();
    expect_out("t3_recover", 2, 1, 0);
    cyc(); expect_out("t3_one", 1, 1, 0);
    cyc(); expect_out("t3_zero", 0, 0, 1);

    // Ignored start, load abort, stop, load+start
    bus.start = 1; cyc(); cyc();
    expect_out("t4_start0", 0, 0, 0);
    bus.load = 1; bus.load_val = 5; cyc();
    bus.start = 1; cyc(); cyc(); cyc();
    expect_out("t4_at3", 3, 1, 0);
    bus.load = 1; bus.load_val = 7; cyc();
    expect_out("t4_reload", 7, 0, 0);
    bus.start = 1; cyc(); cyc(); cyc();
    bus.stop = 1; cyc();
    expect_out("t4_stop", 5, 0, 0);
    bus.load = 1; bus.load_val = 6; bus.start = 1; cyc(); cyc();
    expect_out("t4_load_start", 6, 0, 0);

    // Async reset mid-run
    bus.prescale = 1; bus.load = 1; bus.load_val = 9; cyc();
    bus.start = 1; cyc();
    guard = 0;
    while (bus.count != 6 && guard < 20) begin cyc(); guard++; end
    chk("t5_reach6", int'(bus.count), 6);
    reset = 1'b1; #1;
    expect_out("t5_async", 0, 0, 0);
    @(posedge clk); #2; reset = 1'b0;
    bus.start = 1; cyc(); cyc();
    expect_out("t5_after", 0, 0, 0);

    // Prescale reduced mid-run
    bus.prescale = 7; bus.load = 1; bus.load_val = 9; cyc();
    bus.start = 1; cyc();
    for (int i = 0; i < 5; i++) cyc();
    expect_out("t6_before", 9, 1, 0);
    bus.prescale = 2; cyc();
    expect_out("t6_tick", 8, 1, 0);
    cyc(); cyc();
    chk("t6_wait", int'(bus.count), 8);
    cyc();
    chk("t6_next", int'(bus.count), 7);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) bus.load = 1;
      bus.load_val = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) bus.stop = 1;
      if ($urandom_range(0, 99) < 25) bus.start = 1;
      if ($urandom_range(0, 99) < 10) bus.pause = ~bus.pause;
      if ($urandom_range(0, 99) < 5) bus.auto_reload = ~bus.auto_reload;
      if ($urandom_range(0, 99) < 5) bus.prescale = PRESCALE_W'($urandom_range(0, 3));
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, prescaled down-counter with terminal-count output. It is the counterpart to the team's free-running up counter: it counts a programmed value down to zero instead of up from zero.
- Used as a timeout/interval timer: the controller loads a value, starts the timer, and watches tc.
- Optional auto-reload makes it a periodic tick generator.
- One clock domain; no external handshake beyond load/start/pause/stop strobes.

Parameters:
- WIDTH, 4: width of count, load_val and the internal reload register.
- PRESCALE_W, 4: width of the prescale input and the internal prescaler counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  strobe: capture load_val into the reload register and into count.
- load_val  input  WIDTH  value to load.
- start  input  1  strobe: begin counting down from the current count.
- pause  input  1  level: freeze the timer while high.
- stop  input  1  strobe: abort the run and return to IDLE; count is held.
- auto_reload  input  1  level: on terminal count, reload and keep running.
- prescale  input  PRESCALE_W  count decrements once every prescale+1 running cycles.
- count  output  WIDTH  current count (registered).
- busy  output  1  high in RUN or PAUSED (registered, decoded from the state register).
- tc  output  1  one-cycle terminal-count pulse (registered).

Behaviour:
- Reset (asynchronous, active-high):
  - count=0, reload_reg=0, prescaler=0, state=IDLE, busy=0, tc=0.
  - Takes effect immediately, including mid-run. Normal operation resumes on the first clk edge after reset deasserts.
- States and transitions:
  - IDLE: start=1 and count!=0 -> RUN. start with count==0 is ignored (no tc, busy stays 0).
  - RUN: pause=1 -> PAUSED. stop=1 -> IDLE. Terminal count with auto_reload=0 -> IDLE.
  - PAUSED: pause=0 -> RUN. stop=1 -> IDLE.
- Per-cycle priority (highest first): load > stop > start > pause > tick.
  - load in any state: reload_reg<=load_val, count<=load_val, prescaler<=0, state<=IDLE. Loading aborts a run.
  - stop: state<=IDLE, prescaler<=0, count held.
  - start is ignored in RUN and PAUSED.
- Tick rule:
  - The prescaler advances only in a cycle where state==RUN, pause==0 and no higher-priority event occurs.
  - If prescaler >= prescale: tick; prescaler<=0. Otherwise prescaler<=prescaler+1.
  - Using >= means a prescale value reduced mid-run takes effect at once, with no wrap.
- On a tick:
  - If count>1: count<=count-1.
  - If count==1: tc<=1 for exactly one cycle, coincident with the new count value.
    - auto_reload=1 and reload_reg!=0: count<=reload_reg, stay in RUN.
    - Otherwise: count<=0, state<=IDLE; busy falls on the same edge tc rises.
- Latency and timing:
  - The first tick occurs prescale+1 running cycles after the edge that enters RUN.
  - Total run length: reload*(prescale+1) cycles.
  - Auto-reload period: reload_reg*(prescale+1) cycles. With auto_reload the count never shows 0.
- PAUSED: count and prescaler frozen. The cycle that leaves PAUSED does not advance the prescaler.
- Arithmetic: count never decrements below 0 and never wraps. The prescaler is unsigned PRESCALE_W bits.
- tc is 0 in every cycle without a terminal tick, including load, stop and reset cycles.
- auto_reload is sampled at the terminal tick only; changing it mid-run affects only the next terminal tick.

Test Plan:
1. Basic countdown: WIDTH=4, prescale=0, load_val=5, load, then start, auto_reload=0 -> count 5,4,3,2,1,0 on consecutive edges after RUN entry; tc=1 exactly on the cycle count becomes 0; busy falls on that same edge; count stays 0.
2. Auto-reload with prescale: prescale=2, load 3, auto_reload=1, start -> count steps 3→2→1→3 every 3 cycles; tc pulses every 9 cycles for at least 3 periods; busy stays 1 throughout.
3. Pause: load 4, prescale=0, start; raise pause after count=2 for 5 cycles -> count holds 2 and tc stays 0 during pause; after pause falls, one recovery cycle, then 1, 0 with tc.
4. Abort and ignored events:
   - start with count=0 -> busy stays 0, no tc.
   - load 7 while RUN at count=3 -> count=7, state IDLE, busy=0.
   - stop at count=5 -> count stays 5, busy=0.
   - load and start in the same cycle -> load wins; timer stays IDLE.
5. Async reset mid-run: load 9, prescale=1, start; assert reset between clock edges at count=6 -> count=0, busy=0, tc=0 immediately, before the next edge. After release, start alone does not run (count=0).
6. Prescale reduced mid-run: prescale=7, prescaler reaches 5, set prescale=2 -> tick on the next running cycle, no wrap; subsequent ticks every 3 cycles.
